cacheline_adaptor: RTL and testbench

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

---
 rtl/cacheline_adaptor_pkg.sv | 19 +
 rtl/cacheline_adaptor.sv | 118 +++++++++++
 tb/tb_cacheline_adaptor.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adaptor_pkg.sv
// Shared types for the cache-line to memory-burst adaptor.
package cacheline_adaptor_pkg;

    localparam int BURST_BEATS = 4;
    localparam int BURST_WIDTH = 64;
    localparam int LINE_WIDTH  = BURST_BEATS * BURST_WIDTH;
    localparam int BEAT_IDX_W  = $clog2(BURST_BEATS);

    typedef logic [LINE_WIDTH-1:0] rv32i_line;

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } adaptor_state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cache line request into a 4-beat x 64-bit memory burst.
//
// Handshake: the adaptor holds read_o/write_o high for the whole burst and
// keeps address_o constant; every cycle memory raises resp_i exactly one beat
// is transferred (burst_i captured on reads, burst_o consumed on writes).
// resp_i low stalls the burst. After the fourth beat, resp_o pulses for one
// cycle toward the cache; the cache may start a new request the cycle after.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,

    input  logic [31:0]            address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    input  rv32i_line              line_i,
    output rv32i_line              line_o,
    output logic                   resp_o,

    output logic [31:0]            address_o,
    output logic                   read_o,
    output logic                   write_o,
    output logic [BURST_WIDTH-1:0] burst_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    input  logic                   resp_i
);

    adaptor_state_e        state_q, state_d;
    logic [BEAT_IDX_W-1:0] beat_q, beat_d;
    logic [31:0]           addr_q, addr_d;
    rv32i_line             line_q, line_d;    // assembled fill line
    rv32i_line             wline_q, wline_d;  // latched writeback line

    // Bit offset of the current beat inside a line (beat index * 64).
    logic [7:0] beat_base;
    assign beat_base = {beat_q, 6'd0};

    assign address_o = addr_q;
    assign line_o    = line_q;
    assign burst_o   = wline_q[beat_base +: BURST_WIDTH];

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            wline_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            wline_q <= wline_d;
        end
    end

    // Next-state, datapath updates and state-decoded strobes.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        line_d  = line_q;
        wline_d = wline_q;
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;

        case (state_q)
            IDLE: begin
                // Writeback takes priority over fill when both are requested.
                if (write_i) begin
                    wline_d = line_i;
                    addr_d  = {address_i[31:5], 5'b0};
                    beat_d  = '0;
                    state_d = WR_BURST;
                end else if (read_i) begin
                    addr_d  = {address_i[31:5], 5'b0};
                    beat_d  = '0;
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                read_o = 1'b1;
                if (resp_i) begin
                    line_d[beat_base +: BURST_WIDTH] = burst_i;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BEAT_IDX_W'(BURST_BEATS - 1)) begin
                        state_d = RD_DONE;
                    end
                end
            end
            RD_DONE: begin
                resp_o  = 1'b1;
                state_d = IDLE;
            end
            WR_BURST: begin
                write_o = 1'b1;
                if (resp_i) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BEAT_IDX_W'(BURST_BEATS - 1)) begin
                        state_d = WR_DONE;
                    end
                end
            end
            WR_DONE: begin
                resp_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: transaction-level model of the
// expected outputs, compared every cycle, plus literal pins of known cases.
module tb_cacheline_adaptor;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0]  address_i;
    logic         read_i, write_i;
    logic [255:0] line_i, line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic         read_o, write_o;
    logic [63:0]  burst_o, burst_i;
    logic         resp_i;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i)
    );

    // ---------------- model state ----------------
    int           cyc = 0;
    bit           chk_en = 1'b0;
    logic         exp_read, exp_write, exp_resp, exp_burst_en;
    logic [63:0]  exp_burst;
    logic [31:0]  exp_addr;
    logic [255:0] exp_line;
    bit           just_reset = 1'b1;

    // Effects of the current cycle's inputs, applied at the next clock edge.
    bit           pend_beat = 1'b0;
    int           pend_k;
    logic [63:0]  pend_data;
    bit           pend_addr = 1'b0;
    logic [31:0]  pend_addr_val;
    bit           pend_rst = 1'b0;

    int           req_cyc;
    int           last_resp_cyc, last_wbeat_cyc;
    int           rd_hi_cnt, rd_beat_cnt, resp_cnt;
    logic [63:0]  wr_beats_q[$];

    int           n_pass = 0;
    int           n_total = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic int rg();
        return $urandom_range(0, 2);
    endfunction

    // Advance one cycle and fold the previous cycle's effects into the model.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (pend_beat) begin
            exp_line[64*pend_k +: 64] = pend_data;
            pend_beat = 1'b0;
        end
        if (pend_addr) begin
            exp_addr  = pend_addr_val;
            pend_addr = 1'b0;
        end
        if (pend_rst) begin
            exp_line   = '0;
            exp_addr   = '0;
            pend_rst   = 1'b0;
            just_reset = 1'b1;
        end
    endtask

    task automatic set_exp(input logic rd, input logic wr, input logic rsp,
                           input logic ben, input logic [63:0] b);
        exp_read     = rd;
        exp_write    = wr;
        exp_resp     = rsp;
        exp_burst_en = ben;
        exp_burst    = b;
    endtask

    task automatic noise_req(input bit hold);
        read_i  = hold ? 1'b1 : 1'($urandom_range(0, 1));
        write_i = 1'($urandom_range(0, 1));
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_idle();
        tick();
        rst = 1'b0; read_i = 1'b0; write_i = 1'b0;
        address_i = $urandom; resp_i = 1'($urandom_range(0, 1));
        burst_i = {$urandom, $urandom}; line_i = rand256();
        set_exp(0, 0, 0, just_reset, '0);
        just_reset = 1'b0;
    endtask

    // Line fill; gN = idle cycles before beat N; nbeats < 4 with do_rst aborts.
    task automatic do_fill(input logic [31:0] a, input logic [255:0] data,
                           input int g0, input int g1, input int g2, input int g3,
                           input bit hold, input int nbeats, input bit do_rst);
        int gp[4];
        gp = '{g0, g1, g2, g3};
        tick();
        rst = 1'b0; read_i = 1'b1; write_i = 1'b0; address_i = a;
        resp_i = 1'($urandom_range(0, 1)); burst_i = {$urandom, $urandom}; line_i = rand256();
        set_exp(0, 0, 0, just_reset, '0);
        just_reset = 1'b0;
        req_cyc = cyc;
        pend_addr = 1'b1; pend_addr_val = {a[31:5], 5'b0};
        for (int k = 0; k < nbeats; k++) begin
            for (int g = 0; g < gp[k]; g++) begin
                tick();
                noise_req(hold); resp_i = 1'b0; burst_i = {$urandom, $urandom};
                set_exp(1, 0, 0, 0, '0);
            end
            tick();
            noise_req(hold); resp_i = 1'b1; burst_i = data[64*k +: 64];
            set_exp(1, 0, 0, 0, '0);
            pend_beat = 1'b1; pend_k = k; pend_data = data[64*k +: 64];
        end
        tick();
        if (do_rst) begin
            rst = 1'b1; noise_req(hold); resp_i = 1'b1; burst_i = {$urandom, $urandom};
            set_exp(1, 0, 0, 0, '0);
            pend_rst = 1'b1;
        end else begin
            noise_req(hold); resp_i = 1'($urandom_range(0, 1)); burst_i = {$urandom, $urandom};
            set_exp(0, 0, 1, 0, '0);
        end
    endtask

    // Writeback; both=1 also raises read_i in the request cycle.
    task automatic do_write(input logic [31:0] a, input logic [255:0] data,
                            input int g0, input int g1, input int g2, input int g3,
                            input bit both);
        int gp[4];
        gp = '{g0, g1, g2, g3};
        tick();
        rst = 1'b0; write_i = 1'b1; read_i = both; address_i = a; line_i = data;
        resp_i = 1'($urandom_range(0, 1)); burst_i = {$urandom, $urandom};
        set_exp(0, 0, 0, just_reset, '0);
        just_reset = 1'b0;
        req_cyc = cyc;
        pend_addr = 1'b1; pend_addr_val = {a[31:5], 5'b0};
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gp[k]; g++) begin
                tick();
                noise_req(0); resp_i = 1'b0; line_i = rand256(); burst_i = {$urandom, $urandom};
                set_exp(0, 1, 0, 1, data[64*k +: 64]);
            end
            tick();
            noise_req(0); resp_i = 1'b1; line_i = rand256(); burst_i = {$urandom, $urandom};
            set_exp(0, 1, 0, 1, data[64*k +: 64]);
        end
        tick();
        noise_req(0); resp_i = 1'($urandom_range(0, 1)); line_i = rand256();
        set_exp(0, 0, 1, 0, '0);
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("read_o",    read_o,    exp_read);
            check("write_o",   write_o,   exp_write);
            check("resp_o",    resp_o,    exp_resp);
            check("address_o", address_o, exp_addr);
            check("line_o",    line_o,    exp_line);
            if (exp_burst_en) check("burst_o", burst_o, exp_burst);
            check("rd_wr_exclusive", read_o & write_o, 1'b0);
            if (resp_o) begin
                last_resp_cyc = cyc;
                resp_cnt++;
            end
            if (read_o) rd_hi_cnt++;
            if (read_o && resp_i) rd_beat_cnt++;
            if (write_o && resp_i) begin
                wr_beats_q.push_back(burst_o);
                last_wbeat_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [255:0] fill_lit, wr_lit, d;
        logic [63:0]  wr_exp [4];
        logic [63:0]  got;
        logic [31:0]  a;
        int           op;

        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; address_i = '0;
        line_i = '0; burst_i = '0; resp_i = 1'b0;
        tick();
        tick();
        exp_line = '0; exp_addr = '0;
        set_exp(0, 0, 0, 1, '0);
        chk_en = 1'b1;

        // Fill with back-to-back beats: literal line, aligned address, latency.
        fill_lit = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
        last_resp_cyc = -1;
        do_fill(32'h0000_1234, fill_lit, 0, 0, 0, 0, 0, 4, 0);
        @(negedge clk); #1;
        check("fill_addr_lit", address_o, 32'h0000_1220);
        check("fill_line_lit", line_o, {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}});
        check("fill_latency", last_resp_cyc - req_cyc, 5);

        // Writeback with one idle gap between beats 1 and 2.
        wr_lit = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_89ABCDEF01234567;
        wr_exp = '{64'h89ABCDEF01234567, 64'h0F1E2D3C4B5A6978,
                   64'hFEDCBA9876543210, 64'h0123456789ABCDEF};
        wr_beats_q.delete();
        do_write(32'h8000_0047, wr_lit, 0, 0, 1, 0, 0);
        @(negedge clk); #1;
        check("wr_beat_count", wr_beats_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            got = (wr_beats_q.size() > 0) ? wr_beats_q.pop_front() : 64'hX;
            check("wr_beat_lit", got, wr_exp[i]);
        end
        check("wr_resp_after_last_beat", last_resp_cyc - last_wbeat_cyc, 1);

        // Simultaneous read/write request: write wins, read_o never rises.
        rd_hi_cnt = 0;
        wr_beats_q.delete();
        do_write(32'h0000_0FE0, rand256(), 0, 0, 0, 0, 1);
        @(negedge clk); #1;
        check("both_no_read", rd_hi_cnt, 0);
        check("both_wr_beats", wr_beats_q.size(), 4);
        check("wr_latency", last_resp_cyc - req_cyc, 5);

        // Reset mid-fill after three beats, then an immediate new fill.
        resp_cnt = 0;
        do_fill(32'h1234_5678, rand256(), 0, 1, 0, 0, 0, 3, 1);
        do_fill(32'h0000_2040, rand256(), 1, 0, 2, 0, 0, 4, 0);
        @(negedge clk); #1;
        check("abort_resp_cnt", resp_cnt, 1);

        // read_i held high throughout: one fill per resp_o pulse.
        rd_beat_cnt = 0;
        resp_cnt = 0;
        do_fill(32'hABCD_0000, rand256(), 0, 0, 0, 0, 1, 4, 0);
        do_fill(32'hABCD_0020, rand256(), 0, 1, 0, 1, 1, 4, 0);
        do_idle();
        @(negedge clk); #1;
        check("held_read_beats", rd_beat_cnt, 8);
        check("held_read_resps", resp_cnt, 2);

        // Randomized mix of fills, writebacks and idle cycles.
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 3);
            a  = $urandom;
            d  = rand256();
            case (op)
                0: do_fill(a, d, rg(), rg(), rg(), rg(), 1'($urandom_range(0, 1)), 4, 0);
                1: do_write(a, d, rg(), rg(), rg(), rg(), 0);
                2: do_write(a, d, rg(), rg(), rg(), rg(), 1);
                default: do_idle();
            endcase
        end
        do_idle();
        @(negedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
